// File: rtl/int_rti_sequencer.sv
// Interrupt entry / RTI return sequencer sitting beside EX.
// Entry pushes return PC and {Z,N,C} to the stack and vectors the PC; RTI pops and restores both.
module int_rti_sequencer #(
  parameter logic [31:0] VEC_ADDR  = 32'h0000_0020,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned WDOG_CYC  = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        int_req_i,
  input  logic        int_en_i,
  input  logic        rti_ex_i,
  input  logic        do_jmp_i,
  input  logic [31:0] jmp_addr_i,
  input  logic [31:0] pc_next_i,
  input  logic [2:0]  flags_in_i,
  input  logic        mem_ready_i,
  input  logic [15:0] pop_data_i,
  output logic        stall_fetch_o,
  output logic        flush_front_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  output logic [15:0] mem_wdata_o,
  output logic [1:0]  sp_op_o,
  output logic        pc_load_o,
  output logic [31:0] pc_load_val_o,
  output logic        flags_load_o,
  output logic [2:0]  flags_val_o,
  output logic        clr_int_o,
  output logic        int_ack_o,
  output logic        busy_o,
  output logic        err_timeout_o
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FLG_W   = 3;
  localparam int unsigned SP_W    = 2;
  localparam int unsigned CNT_MAX = (WDOG_CYC > DRAIN_CYC) ? WDOG_CYC : DRAIN_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [SP_W-1:0] SP_HOLD = SP_W'(0);
  localparam logic [SP_W-1:0] SP_PUSH = SP_W'(1);
  localparam logic [SP_W-1:0] SP_POP  = SP_W'(2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_FLG,
    S_VECTOR,
    S_RTI_DRAIN,
    S_POP_FLG,
    S_POP_PCL,
    S_POP_PCH,
    S_RESUME
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, cyc_sat;
  logic               pend_q, pend_d;
  logic               int_req_q;
  logic [PC_W-1:0]    ret_pc_q, ret_pc_d;
  logic [FLG_W-1:0]   ret_flg_q, ret_flg_d;
  logic [PC_W-1:0]    pop_pc_q, pop_pc_d;
  logic [FLG_W-1:0]   pop_flg_q, pop_flg_d;
  logic               stay, in_mem, drain_done;

  logic               stall_q, stall_d;
  logic               flush_q, flush_d;
  logic               mem_write_q, mem_write_d;
  logic               mem_read_q, mem_read_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [SP_W-1:0]    sp_op_q, sp_op_d;
  logic               pc_load_q, pc_load_d;
  logic [PC_W-1:0]    pc_load_val_q, pc_load_val_d;
  logic               flags_load_q, flags_load_d;
  logic [FLG_W-1:0]   flags_val_q, flags_val_d;
  logic               int_ack_q, int_ack_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  assign drain_done = (cyc_q == CNT_W'(DRAIN_CYC));
  assign cyc_sat    = (cyc_q == CNT_W'(CNT_MAX)) ? cyc_q : cyc_q + CNT_W'(1);

  // Next-state and capture of return / popped context
  always_comb begin
    state_d   = state_q;
    ret_pc_d  = ret_pc_q;
    ret_flg_d = ret_flg_q;
    pop_pc_d  = pop_pc_q;
    pop_flg_d = pop_flg_q;
    unique case (state_q)
      S_IDLE: begin
        if (rti_ex_i || (pend_q && int_en_i)) begin
          state_d   = rti_ex_i ? S_RTI_DRAIN : S_DRAIN;
          ret_pc_d  = do_jmp_i ? jmp_addr_i : pc_next_i;
          ret_flg_d = flags_in_i;
        end
      end
      S_DRAIN:     if (drain_done)  state_d = S_PUSH_PCH;
      S_PUSH_PCH:  if (mem_ready_i) state_d = S_PUSH_PCL;
      S_PUSH_PCL:  if (mem_ready_i) state_d = S_PUSH_FLG;
      S_PUSH_FLG:  if (mem_ready_i) state_d = S_VECTOR;
      S_VECTOR:    state_d = S_IDLE;
      S_RTI_DRAIN: if (drain_done)  state_d = S_POP_FLG;
      S_POP_FLG: begin
        if (mem_ready_i) begin
          state_d   = S_POP_PCL;
          pop_flg_d = pop_data_i[FLG_W-1:0];
        end
      end
      S_POP_PCL: begin
        if (mem_ready_i) begin
          state_d                 = S_POP_PCH;
          pop_pc_d[DATA_W-1:0]    = pop_data_i;
        end
      end
      S_POP_PCH: begin
        if (mem_ready_i) begin
          state_d                 = S_RESUME;
          pop_pc_d[PC_W-1:DATA_W] = pop_data_i;
        end
      end
      S_RESUME:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Cycle counter (drain length and handshake watchdog) and pending latch
  always_comb begin
    in_mem = 1'b0;
    unique case (state_q)
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_FLG,
      S_POP_FLG, S_POP_PCL, S_POP_PCH: in_mem = 1'b1;
      default:                         in_mem = 1'b0;
    endcase
    stay   = (state_d == state_q);
    cyc_d  = stay ? cyc_sat : '0;
    err_d  = in_mem && stay && (cyc_q == CNT_W'(WDOG_CYC - 1));
    // A new edge wins over the clear so an INT raised during entry is not lost
    pend_d = (int_req_i && !int_req_q) ||
             (pend_q && !(state_d == S_PUSH_PCH && state_q != S_PUSH_PCH));
  end

  // Output decode from the next state so every strobe leaves a flop
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    flush_d       = (state_q == S_IDLE) && (state_d != S_IDLE);
    stall_d       = (state_q != S_IDLE) && (state_d != S_IDLE);
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_wdata_d   = '0;
    sp_op_d       = SP_HOLD;
    pc_load_d     = 1'b0;
    pc_load_val_d = '0;
    flags_load_d  = 1'b0;
    flags_val_d   = '0;
    int_ack_d     = 1'b0;
    unique case (state_d)
      S_PUSH_PCH: begin
        mem_write_d = 1'b1;
        sp_op_d     = SP_PUSH;
        mem_wdata_d = ret_pc_d[PC_W-1:DATA_W];
      end
      S_PUSH_PCL: begin
        mem_write_d = 1'b1;
        sp_op_d     = SP_PUSH;
        mem_wdata_d = ret_pc_d[DATA_W-1:0];
      end
      S_PUSH_FLG: begin
        mem_write_d = 1'b1;
        sp_op_d     = SP_PUSH;
        mem_wdata_d = {{(DATA_W-FLG_W){1'b0}}, ret_flg_d};
      end
      S_VECTOR: begin
        pc_load_d     = 1'b1;
        pc_load_val_d = VEC_ADDR;
        int_ack_d     = 1'b1;
      end
      S_POP_FLG, S_POP_PCL, S_POP_PCH: begin
        mem_read_d = 1'b1;
        sp_op_d    = SP_POP;
      end
      S_RESUME: begin
        pc_load_d     = 1'b1;
        pc_load_val_d = pop_pc_d;
        flags_load_d  = 1'b1;
        flags_val_d   = pop_flg_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= S_IDLE;
      cyc_q         <= '0;
      pend_q        <= 1'b0;
      int_req_q     <= 1'b0;
      ret_pc_q      <= '0;
      ret_flg_q     <= '0;
      pop_pc_q      <= '0;
      pop_flg_q     <= '0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_wdata_q   <= '0;
      sp_op_q       <= SP_HOLD;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      flags_load_q  <= 1'b0;
      flags_val_q   <= '0;
      int_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      pend_q        <= pend_d;
      int_req_q     <= int_req_i;
      ret_pc_q      <= ret_pc_d;
      ret_flg_q     <= ret_flg_d;
      pop_pc_q      <= pop_pc_d;
      pop_flg_q     <= pop_flg_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_wdata_q   <= mem_wdata_d;
      sp_op_q       <= sp_op_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      flags_load_q  <= flags_load_d;
      flags_val_q   <= flags_val_d;
      int_ack_q     <= int_ack_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign stall_fetch_o = stall_q;
  assign flush_front_o = flush_q;
  assign mem_write_o   = mem_write_q;
  assign mem_read_o    = mem_read_q;
  assign mem_wdata_o   = mem_wdata_q;
  // Stack pointer only moves in the accepting cycle of a handshake
  assign sp_op_o       = mem_ready_i ? sp_op_q : SP_HOLD;
  assign pc_load_o     = pc_load_q;
  assign pc_load_val_o = pc_load_val_q;
  assign flags_load_o  = flags_load_q;
  assign flags_val_o   = flags_val_q;
  assign clr_int_o     = int_ack_q;
  assign int_ack_o     = int_ack_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;

endmodule
